// File: rtl/fwft_fifo_unpacker.sv
// Drains a first-word-fall-through FIFO and replays each wide word as RATIO narrow
// beats, LSB slice first, with optional m_last framing every PKT_LEN beats.
module fwft_fifo_unpacker #(
   parameter int IN_WIDTH = 32,
   parameter int RATIO    = 4,
   parameter int PKT_LEN  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [IN_WIDTH-1:0]       fifo_rdata,
   input  logic                      fifo_rdata_vld,
   output logic                      fifo_rden,
   output logic [IN_WIDTH/RATIO-1:0] m_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic                      m_last,
   output logic [31:0]               pkt_count
);

   localparam int OUT_WIDTH = IN_WIDTH / RATIO;
   localparam int IDX_W     = (RATIO > 1) ? $clog2(RATIO) : 1;

   logic [IN_WIDTH-1:0] hreg_q, hreg_d;
   logic                hold_vld_q, hold_vld_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [31:0]         pkt_count_q, pkt_count_d;
   logic                acc, lastsl, rden;

   assign acc    = hold_vld_q & m_ready;
   assign lastsl = (idx_q == IDX_W'(RATIO - 1));
   // Popping in the same cycle as the last slice is accepted keeps the stream gapless.
   assign rden   = fifo_rdata_vld & ~rst & (~hold_vld_q | (acc & lastsl));

   always_comb begin
      hreg_d     = hreg_q;
      hold_vld_d = hold_vld_q;
      idx_d      = idx_q;
      if (rden) begin
         hreg_d     = fifo_rdata;
         hold_vld_d = 1'b1;
         idx_d      = '0;
      end else if (acc) begin
         if (lastsl) begin
            hold_vld_d = 1'b0;
            idx_d      = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   always_comb begin
      pkt_count_d = pkt_count_q;
      if (acc & m_last) pkt_count_d = pkt_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      hreg_q <= hreg_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_vld_q  <= 1'b0;
         idx_q       <= '0;
         pkt_count_q <= '0;
      end else begin
         hold_vld_q  <= hold_vld_d;
         idx_q       <= idx_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   // Packet framing runs on accepted beats only, independent of word boundaries.
   generate
      if (PKT_LEN > 0) begin : g_frame
         localparam int BC_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
         logic [BC_W-1:0] bcnt_q, bcnt_d;
         logic            bcnt_wrap;

         assign bcnt_wrap = (bcnt_q == BC_W'(PKT_LEN - 1));
         assign m_last    = hold_vld_q & bcnt_wrap;

         always_comb begin
            bcnt_d = bcnt_q;
            if (acc) bcnt_d = bcnt_wrap ? '0 : bcnt_q + BC_W'(1);
         end

         always_ff @(posedge clk) begin
            if (rst) bcnt_q <= '0;
            else     bcnt_q <= bcnt_d;
         end
      end else begin : g_noframe
         assign m_last = 1'b0;
      end
   endgenerate

   assign fifo_rden = rden;
   assign m_valid   = hold_vld_q;
   assign m_data    = hreg_q[idx_q*OUT_WIDTH +: OUT_WIDTH];
   assign pkt_count = pkt_count_q;

endmodule
